// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE controller.
// Holds FSM encoding, default parameters and counter width helper.
package pe_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_MACS_DEF   = 64;
  localparam int K_MAX_DEF      = 256;
  localparam int T_MAX_DEF      = 256;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int PE_LAT_DEF     = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_e;

  // Bits needed to hold 0..max_v inclusive.
  function automatic int cnt_w(input int max_v);
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/pe_ctrl_addr_gen.sv
// Operand address counters for the PE controller.
// A runs across the whole job; B restarts at its base every tile.
module pe_ctrl_addr_gen
  import pe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] a_base_i,
  input  logic [ADDR_WIDTH-1:0] b_base_i,
  input  logic                  b_rst_i,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] a_addr_o,
  output logic [ADDR_WIDTH-1:0] b_addr_o
);

  logic [ADDR_WIDTH-1:0] a_q;
  logic [ADDR_WIDTH-1:0] b_q;
  logic [ADDR_WIDTH-1:0] b_base_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      b_base_q <= '0;
    end else if (load_i) begin
      a_q      <= a_base_i;
      b_q      <= b_base_i;
      b_base_q <= b_base_i;
    end else if (b_rst_i) begin
      b_q <= b_base_q;
    end else if (adv_i) begin
      a_q <= a_q + ADDR_WIDTH'(1);
      b_q <= b_q + ADDR_WIDTH'(1);
    end
  end

  assign a_addr_o = a_q;
  assign b_addr_o = b_q;

endmodule

// File: rtl/pe_ctrl.sv
// Job sequencer feeding operands to a MAC PE, one tile at a time.
// Optional PE_CTRL_PERF_EN adds a 32-bit busy-cycle counter output.
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_MACS   = NUM_MACS_DEF,
  parameter int K_MAX      = K_MAX_DEF,
  parameter int T_MAX      = T_MAX_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PE_LAT     = PE_LAT_DEF,
  localparam int KW = cnt_w(K_MAX),
  localparam int TW = cnt_w(T_MAX),
  localparam int PW = NUM_MACS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [KW-1:0]         cmd_k,
  input  logic [TW-1:0]         cmd_tiles,
  input  logic [ADDR_WIDTH-1:0] cmd_a_base,
  input  logic [ADDR_WIDTH-1:0] cmd_b_base,
  input  logic [1:0]            cmd_tsk,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  pe_mac_en,
  output logic                  pe_rst_mac,
  output logic [1:0]            pe_tsk_ctrl,
  input  logic [PW-1:0]         pe_o_packed,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [PW-1:0]         res_data,
  output logic [TW-1:0]         res_tile_idx,
  output logic                  busy,
  output logic                  done
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam logic [7:0] LAT8 = 8'(PE_LAT);

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   kcnt_q;
  logic [TW-1:0]   tiles_q;
  logic [TW-1:0]   tile_q;
  logic [7:0]      dcnt_q;
  logic [1:0]      tsk_q;
  logic            cmd_ready_q;
  logic            rd_en_q;
  logic            mac_en_q;
  logic            rst_mac_q;
  logic            res_valid_q;
  logic [PW-1:0]   res_data_q;
  logic [TW-1:0]   res_idx_q;
  logic            busy_q;
  logic            done_q;

  logic            accept;
  logic [KW-1:0]   k_in;
  logic [TW-1:0]   t_in;

  assign accept = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;
  assign k_in   = (cmd_k > KW'(K_MAX)) ? KW'(K_MAX) : cmd_k;
  assign t_in   = (cmd_tiles > TW'(T_MAX)) ? TW'(T_MAX) : cmd_tiles;

  pe_ctrl_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .a_base_i (cmd_a_base),
    .b_base_i (cmd_b_base),
    .b_rst_i  (state_q == S_CLEAR),
    .adv_i    (state_q == S_FEED),
    .a_addr_o (a_addr),
    .b_addr_o (b_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      kcnt_q      <= '0;
      tiles_q     <= '0;
      tile_q      <= '0;
      dcnt_q      <= '0;
      tsk_q       <= '0;
      cmd_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      rst_mac_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rst_mac_q <= 1'b0;
      // Operand memory has one cycle of read latency.
      mac_en_q  <= rd_en_q;
      unique case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          tsk_q       <= '0;
          if (accept) begin
            k_q     <= k_in;
            tiles_q <= t_in;
            tile_q  <= '0;
            if (k_in == '0 || t_in == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= S_CLEAR;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              tsk_q       <= cmd_tsk;
              rst_mac_q   <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          state_q <= S_FEED;
          rd_en_q <= 1'b1;
          kcnt_q  <= '0;
        end
        S_FEED: begin
          kcnt_q <= kcnt_q + KW'(1);
          if (kcnt_q == k_q - KW'(1)) begin
            rd_en_q <= 1'b0;
            dcnt_q  <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          dcnt_q <= dcnt_q + 8'd1;
          if (dcnt_q == LAT8) begin
            res_data_q  <= pe_o_packed;
            res_idx_q   <= tile_q;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (tile_q == tiles_q - TW'(1)) begin
              state_q     <= S_IDLE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              tsk_q       <= '0;
            end else begin
              tile_q    <= tile_q + TW'(1);
              rst_mac_q <= 1'b1;
              state_q   <= S_CLEAR;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy_q) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign cmd_ready    = cmd_ready_q;
  assign rd_en        = rd_en_q;
  assign pe_mac_en    = mac_en_q;
  assign pe_rst_mac   = rst_mac_q;
  assign pe_tsk_ctrl  = tsk_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_tile_idx = res_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl with a two-lane dot-product PE stub.
// Vector table drives whole jobs; hand sequences cover stall/reset.
module tb_pe_ctrl;

  localparam int DW = 8;
  localparam int NM = 2;
  localparam int KM = 16;
  localparam int TM = 4;
  localparam int AW = 8;
  localparam int KW = $clog2(KM + 1);
  localparam int TW = $clog2(TM + 1);
  localparam int PW = NM * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [KW-1:0] cmd_k = '0;
  logic [TW-1:0] cmd_tiles = '0;
  logic [AW-1:0] cmd_a_base = '0;
  logic [AW-1:0] cmd_b_base = '0;
  logic [1:0]    cmd_tsk = '0;
  logic          rd_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          pe_mac_en;
  logic          pe_rst_mac;
  logic [1:0]    pe_tsk_ctrl;
  logic [PW-1:0] pe_o_packed;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [PW-1:0] res_data;
  logic [TW-1:0] res_tile_idx;
  logic          busy;
  logic          done;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  pe_ctrl #(
    .DATA_WIDTH(DW), .NUM_MACS(NM), .K_MAX(KM),
    .T_MAX(TM), .ADDR_WIDTH(AW), .PE_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k(cmd_k), .cmd_tiles(cmd_tiles),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base),
    .cmd_tsk(cmd_tsk),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .pe_mac_en(pe_mac_en), .pe_rst_mac(pe_rst_mac),
    .pe_tsk_ctrl(pe_tsk_ctrl), .pe_o_packed(pe_o_packed),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tile_idx(res_tile_idx),
    .busy(busy), .done(done)
`ifdef PE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Operand memory (1-cycle read) and PE stub (lane0 sum a*b, lane1 sum a).
  logic [7:0] mem [256];
  logic [7:0] ra = '0;
  logic [7:0] rb = '0;
  logic [7:0] acc0 = '0;
  logic [7:0] acc1 = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      ra <= mem[a_addr];
      rb <= mem[b_addr];
    end
    if (pe_rst_mac) begin
      acc0 <= '0;
      acc1 <= '0;
    end else if (pe_mac_en) begin
      acc0 <= acc0 + ra * rb;
      acc1 <= acc1 + ra;
    end
  end

  assign pe_o_packed = {acc1, acc0};

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic [KW-1:0]  k;
    logic [TW-1:0]  t;
    logic [7:0]     a;
    logic [7:0]     b;
    logic [1:0]     tsk;
    int             ek;
    int             et;
    logic [3:0][7:0] l0;
    logic [3:0][7:0] l1;
  } vec_t;

  function automatic vec_t mk(input int k, input int t, input int a,
                              input int b, input int tsk, input int ek,
                              input int et, input logic [31:0] l0,
                              input logic [31:0] l1);
    vec_t v;
    v.k = KW'(k);
    v.t = TW'(t);
    v.a = 8'(a);
    v.b = 8'(b);
    v.tsk = 2'(tsk);
    v.ek = ek;
    v.et = et;
    v.l0 = l0;
    v.l1 = l1;
    return v;
  endfunction

  task automatic issue(input logic [KW-1:0] k, input logic [TW-1:0] t,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] tsk);
    cmd_valid  = 1'b1;
    cmd_k      = k;
    cmd_tiles  = t;
    cmd_a_base = a;
    cmd_b_base = b;
    cmd_tsk    = tsk;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int beats = 0, rstm = 0, dones = 0, tile = 0, bt = 0;
    logic [7:0] ea;
    logic prev_rd = 1'b0;
    logic exp_busy;
    ea = v.a;
    @(negedge clk);
    check("cmd_ready_pre", {31'd0, cmd_ready}, 1);
    issue(v.k, v.t, v.a, v.b, v.tsk);
    for (int cyc = 0; cyc < 300 && dones == 0; cyc++) begin
      @(negedge clk);
      res_ready = 1'b0;
      exp_busy = !done && (v.et != 0);
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, !exp_busy});
      check("tsk", {30'd0, pe_tsk_ctrl},
            exp_busy ? {30'd0, v.tsk} : 32'd0);
      check("mac_lag", {31'd0, pe_mac_en}, {31'd0, prev_rd});
      prev_rd = rd_en;
      if (pe_rst_mac) begin
        rstm++;
        bt = 0;
      end
      if (rd_en) begin
        check("a_addr", {24'd0, a_addr}, {24'd0, ea});
        check("b_addr", {24'd0, b_addr}, {24'd0, 8'(v.b + 8'(bt))});
        ea = ea + 8'd1;
        bt++;
        beats++;
      end
      if (res_valid && tile < 4) begin
        check("res_lane0", {24'd0, res_data[7:0]}, {24'd0, v.l0[tile]});
        check("res_lane1", {24'd0, res_data[15:8]}, {24'd0, v.l1[tile]});
        check("res_tile_idx", {29'd0, res_tile_idx}, 32'(tile));
        tile++;
        res_ready = 1'b1;
      end
      if (done) dones++;
    end
    check("beats", 32'(beats), 32'(v.ek * v.et));
    check("rst_mac_cnt", 32'(rstm), 32'(v.et));
    check("tiles_seen", 32'(tile), 32'(v.et));
    check("done_cnt", 32'(dones), 1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int c;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 1;  mem[8'h11] = 6;  mem[8'h12] = 11; mem[8'h13] = 16;
    mem[8'h14] = 2;  mem[8'h15] = 3;  mem[8'h16] = 4;  mem[8'h17] = 5;
    mem[8'h20] = 1;  mem[8'h21] = 2;  mem[8'h22] = 3;  mem[8'h23] = 4;
    mem[8'hFE] = 1;  mem[8'hFF] = 2;  mem[8'h00] = 3;  mem[8'h01] = 4;

    vecs[0] = mk(4, 1, 'h10, 'h20, 1, 4, 1, 32'd110, 32'd34);
    vecs[1] = mk(4, 2, 'h10, 'h20, 2, 4, 2,
                 {16'd0, 8'd40, 8'd110}, {16'd0, 8'd14, 8'd34});
    vecs[2] = mk(0, 3, 'h10, 'h20, 1, 0, 0, 32'd0, 32'd0);
    vecs[3] = mk(4, 0, 'h10, 'h20, 2, 0, 0, 32'd0, 32'd0);
    vecs[4] = mk(4, 1, 'hFE, 'h20, 3, 4, 1, 32'd30, 32'd10);
    vecs[5] = mk(20, 1, 'h10, 'h20, 1, 16, 1, 32'd110, 32'd48);
    vecs[6] = mk(1, 6, 'h10, 'h20, 2, 1, 4,
                 {8'd16, 8'd11, 8'd6, 8'd1}, {8'd16, 8'd11, 8'd6, 8'd1});

    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("ready_after_rst", {31'd0, cmd_ready}, 1);

    foreach (vecs[i]) run_job(vecs[i]);

    // Result held while the consumer stalls.
    @(negedge clk);
    issue(4, 1, 8'h10, 8'h20, 2'd1);
    c = 0;
    while (c < 50 && !res_valid) begin
      @(negedge clk);
      c++;
    end
    check("hold_reached", {31'd0, res_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, res_valid}, 1);
      check("stall_data", {16'd0, res_data}, 32'h226E);
      check("stall_rd_en", {31'd0, rd_en}, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("stall_release", {31'd0, res_valid}, 0);
    check("stall_done", {31'd0, done}, 1);
    // New command in the done cycle.
    check("done_cycle_ready", {31'd0, cmd_ready}, 1);
    issue(0, 1, 8'h10, 8'h20, 2'd1);
    @(negedge clk);
    check("done_cycle_accept", {31'd0, done}, 1);

    // Reset during the second feed beat.
    @(negedge clk);
    issue(4, 1, 8'h10, 8'h20, 2'd3);
    c = 0;
    begin
      int beats = 0;
      while (c < 50 && beats < 2) begin
        @(negedge clk);
        if (rd_en) beats++;
        c++;
      end
      check("reach_beat2", 32'(beats), 2);
    end
    rst = 1'b0;
    #1;
    check("rst_ctl", {25'd0, cmd_ready, rd_en, pe_mac_en, pe_rst_mac,
                      busy, done, res_valid}, 0);
    check("rst_addr", {16'd0, a_addr, b_addr}, 0);
    check("rst_res", {13'd0, res_tile_idx, res_data}, 0);
    check("rst_tsk", {30'd0, pe_tsk_ctrl}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_held_low", {31'd0, cmd_ready}, 0);
    @(posedge clk);
    #1 check("ready_rise", {31'd0, cmd_ready}, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_ctrl.md
PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 8, element width; NUM_MACS, 64, MAC lanes in PE; K_MAX, 256, max reduction depth; T_MAX, 256, max tiles per job; ADDR_WIDTH, 16, operand memory address width; PE_LAT, 1, cycles from last pe_mac_en beat to valid pe_o_packed.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, asynchronous active-low reset
- cmd_valid, in, 1, job request
- cmd_ready, out, 1, job accept
- cmd_k, in, KW=$clog2(K_MAX+1), reduction depth
- cmd_tiles, in, TW=$clog2(T_MAX+1), tile count
- cmd_a_base, in, ADDR_WIDTH, A operand base
- cmd_b_base, in, ADDR_WIDTH, B vector base
- cmd_tsk, in, 2, PE task code
- rd_en, out, 1, operand memory read strobe
- a_addr, out, ADDR_WIDTH, A read address
- b_addr, out, ADDR_WIDTH, B read address
- pe_mac_en, out, 1, PE accumulate enable
- pe_rst_mac, out, 1, PE accumulator clear
- pe_tsk_ctrl, out, 2, PE task code
- pe_o_packed, in, NUM_MACS*DATA_WIDTH, PE result
- res_valid, out, 1, result available
- res_ready, in, 1, result accept
- res_data, out, NUM_MACS*DATA_WIDTH, captured tile result
- res_tile_idx, out, TW, tile index of res_data
- busy, out, 1, job in progress
- done, out, 1, one-cycle job-complete pulse

Function
REQ-004 SHALL implement FSM IDLE, CLEAR, FEED, DRAIN, HOLD.
REQ-005 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch all cmd_* fields; go to CLEAR, or stay IDLE with done pulsed next cycle if cmd_k==0 or cmd_tiles==0.
REQ-006 CLEAR: pe_rst_mac=1 for exactly one cycle, pe_mac_en=0, k counter=0; go to FEED.
REQ-007 FEED: rd_en=1 for exactly cmd_k consecutive cycles; a_addr starts at a_base and increments by 1 per beat across the whole job (tile-major, k-minor); b_addr=b_base+k, restarting at b_base each tile.
REQ-008 pe_mac_en SHALL equal rd_en delayed one cycle (1-cycle memory read latency).
REQ-009 DRAIN: wait 1+PE_LAT cycles after last rd_en, then register pe_o_packed into res_data and tile index into res_tile_idx; go to HOLD.
REQ-010 HOLD: res_valid=1, res_data and res_tile_idx stable until res_ready; on handshake go to CLEAR with tile+1, or, on the last tile, to IDLE with done=1 for one cycle.
REQ-011 res_ready while res_valid=0 SHALL be ignored; cmd_valid outside IDLE SHALL be ignored.
REQ-012 A command presented in the done cycle SHALL be accepted that cycle.
REQ-013 pe_tsk_ctrl SHALL equal the latched cmd_tsk while busy, 0 in IDLE.
REQ-014 busy SHALL be 1 in all states except IDLE.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-016 cmd_k>K_MAX or cmd_tiles>T_MAX SHALL be clamped to the maximum.

Reset
REQ-017 Asserting rst in any state, including mid-FEED, SHALL immediately force IDLE, clear all counters, and drive every output to 0, including cmd_ready.
REQ-018 cmd_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-019 With PE_CTRL_PERF_EN defined, SHALL add output perf_cycles (32-bit): it counts busy cycles of the current job, holds the value after done, clears on the next accept, and resets to 0.
REQ-020 Without PE_CTRL_PERF_EN, perf_cycles and its counter SHALL not exist.

Structure
REQ-021 Package pe_ctrl_pkg SHALL hold the FSM state encoding, default parameter constants and the KW/TW width functions.
REQ-022 Address counters SHALL live in one sub-module, pe_ctrl_addr_gen.

Verification
REQ-023 K=4, tiles=1, a_base=0x10, b_base=0x20, A={1,6,11,16}, B={1,2,3,4}, dot-product PE stub -> pe_rst_mac 1 cycle; rd_en 4 cycles, a_addr 0x10-0x13, b_addr 0x20-0x23; pe_mac_en lags rd_en by 1; res_valid with lane0=110; done after handshake.
REQ-024 K=4, tiles=2 -> a_addr 0x10-0x17 continuous; b_addr 0x20-0x23 twice; res_tile_idx 0 then 1; one done pulse.
REQ-025 res_ready held low 5 cycles in HOLD -> res_valid and res_data stable; no rd_en; resume on ready.
REQ-026 cmd_k=0 -> accepted, done 1 cycle later; no rd_en, pe_mac_en or pe_rst_mac.
REQ-027 rst asserted at FEED beat 2 -> all outputs 0 immediately; cmd_ready=1 one edge after release.
REQ-028 ADDR_WIDTH=8, a_base=0xFE, K=4 -> a_addr 0xFE, 0xFF, 0x00, 0x01.
